// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: FSM encoding,
// RISC-V funct3 width codes and the access legality check.
package lsu_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned DATA_W  = 32;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD     = 3'd1;
  localparam logic [STATE_W-1:0] ST_RMW_READ = 3'd2;
  localparam logic [STATE_W-1:0] ST_WRITE    = 3'd3;
  localparam logic [STATE_W-1:0] ST_RESP     = 3'd4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic              is_store;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;

  // Misaligned half/word, reserved codes, and unsigned widths on stores are illegal.
  function automatic logic lsu_is_err(input logic is_store, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic err;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_BU:   err = is_store;
      F3_H:    err = addr_lo[0];
      F3_HU:   err = is_store | addr_lo[0];
      F3_W:    err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts and extends load data from a memory word and
// merges sub-word store data into a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_word,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte       = 8'h00;
    w_half       = 16'h0000;
    o_load_data  = '0;
    o_store_word = i_word;

    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'h000000, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'h0000, w_half};
      F3_W:    o_load_data = i_word;
      default: o_load_data = '0;
    endcase

    // Only the addressed lanes are replaced; the rest keep the read-back word.
    case (i_funct3)
      F3_B: begin
        case (i_addr_lo)
          2'd0:    o_store_word[7:0]   = i_wdata[7:0];
          2'd1:    o_store_word[15:8]  = i_wdata[7:0];
          2'd2:    o_store_word[23:16] = i_wdata[7:0];
          default: o_store_word[31:24] = i_wdata[7:0];
        endcase
      end
      F3_H: begin
        if (i_addr_lo[1]) o_store_word[31:16] = i_wdata[15:0];
        else              o_store_word[15:0]  = i_wdata[15:0];
      end
      default: o_store_word = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a CPU request port and a word
// memory with async read; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_din,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_W-1:0]     mem_dout
);

  logic [STATE_W-1:0]    r_state, w_state_nxt;
  lsu_req_t              r_req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_req_ready, r_resp_valid, r_resp_err, r_mem_read, r_mem_write;
  logic [DATA_W-1:0]     r_resp_rdata, r_mem_din;
  logic [ADDR_WIDTH-1:0] r_mem_addr;

  logic                  w_accept, w_err;
  logic                  w_resp_err_nxt;
  logic [DATA_W-1:0]     w_resp_rdata_nxt, w_mem_din_nxt;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [DATA_W-1:0]     w_load_data, w_store_word;

  assign w_accept = req_valid & (r_state == ST_IDLE);
  assign w_err    = lsu_is_err(req_is_store, req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .i_funct3     (r_req.funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_word       (mem_dout),
    .i_wdata      (r_req.wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    w_mem_din_nxt    = '0;
    w_word_addr      = {r_addr[ADDR_WIDTH-1:2], 2'b00};

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          if (w_err) begin
            w_state_nxt      = ST_RESP;
            w_resp_rdata_nxt = '0;
            w_resp_err_nxt   = 1'b1;
          end else if (!req_is_store) begin
            w_state_nxt = ST_LOAD;
          end else if (req_funct3 == F3_W) begin
            w_state_nxt   = ST_WRITE;
            w_mem_din_nxt = req_wdata;
          end else begin
            w_state_nxt = ST_RMW_READ;
          end
        end
      end
      ST_LOAD: begin
        w_state_nxt      = ST_RESP;
        w_resp_rdata_nxt = w_load_data;
        w_resp_err_nxt   = 1'b0;
      end
      ST_RMW_READ: begin
        w_state_nxt   = ST_WRITE;
        w_mem_din_nxt = w_store_word;
      end
      ST_WRITE: begin
        w_state_nxt      = ST_RESP;
        w_resp_rdata_nxt = '0;
        w_resp_err_nxt   = 1'b0;
      end
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= (w_state_nxt == ST_IDLE);
      r_resp_valid <= (w_state_nxt == ST_RESP);
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_mem_read   <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RMW_READ);
      r_mem_write  <= (w_state_nxt == ST_WRITE);
      r_mem_addr   <= ((w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RMW_READ) ||
                       (w_state_nxt == ST_WRITE)) ? w_word_addr : '0;
      r_mem_din    <= w_mem_din_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req  <= '{is_store: req_is_store, funct3: req_funct3, wdata: req_wdata};
      r_addr <= req_addr;
    end
  end

  // Reset masks outputs immediately so a WRITE cycle hit by reset never commits.
  assign req_ready  = reset | r_req_ready;
  assign resp_valid = ~reset & r_resp_valid;
  assign resp_rdata = reset ? '0 : r_resp_rdata;
  assign resp_err   = ~reset & r_resp_err;
  assign mem_read   = ~reset & r_mem_read;
  assign mem_write  = ~reset & r_mem_write;
  assign mem_addr   = reset ? '0 : r_mem_addr;
  assign mem_din    = reset ? '0 : r_mem_din;

endmodule
